// File: rtl/spi_pkg.sv
// Shared SPI slave types and constants: FSM state encoding, RAM command codes, frame length.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_t;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    localparam int FRAME_BITS = 10;

    // True when the command bits of a completed word agree with the state that received it.
    function automatic logic cmd_matches(input state_t st, input logic [1:0] cmd);
        case (st)
            WRITE:     return (cmd == CMD_WR_ADDR) || (cmd == CMD_WR_DATA);
            READ_ADD:  return cmd == CMD_RD_ADDR;
            READ_DATA: return cmd == CMD_RD_DATA;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/spi_tx_shifter.sv
// MISO serializer: loads a RAM byte and presents it MSB first, one bit per clock, then idles at 0.
module spi_tx_shifter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] data,
    output logic         miso,
    output logic         busy,
    output logic         done
);
    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  sreg;
    logic [CW-1:0] bits_left;

    // Clear (frame end) has priority over a load arriving on the same edge.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            sreg      <= '0;
            bits_left <= '0;
            done      <= 1'b0;
        end else if (load) begin
            sreg      <= data;
            bits_left <= CW'(W);
            done      <= 1'b0;
        end else if (bits_left != '0) begin
            sreg      <= {sreg[W-2:0], 1'b0};
            bits_left <= bits_left - CW'(1);
            if (bits_left == CW'(1)) begin
                done <= 1'b1;
            end
        end
    end

    assign busy = (bits_left != '0);
    assign miso = busy & sreg[W-1];

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI slave front end for the single-port RAM: decodes MOSI frames into RAM words and serializes read data on MISO.
// Optional build macro SPI_CMD_CHECK_EN rejects words whose command bits disagree with the decoded state and raises cmd_err.
module spi_slave_ctrl
    import spi_pkg::*;
#(
    parameter int ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 SS_n,
    input  logic                 MOSI,
    output logic                 MISO,
    output logic [ADDR_SIZE+1:0] din,
    output logic                 rx_valid,
    input  logic [ADDR_SIZE-1:0] dout,
    input  logic                 tx_valid,
    output logic                 cmd_err
);
    localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);
    localparam logic [3:0] FULL_CNT = 4'(FRAME_BITS);

    state_t               state;
    state_t               next_state;
    logic [3:0]           bit_cnt;
    logic                 rd_addr_pending;
    logic                 rd_word_ok;
    logic                 shifting;
    logic                 last_bit;
    logic                 cmd_ok;
    logic                 accept;
    logic                 tx_load;
    logic                 tx_busy;
    logic                 tx_done;
    logic [ADDR_SIZE+1:0] word_next;

    always_comb begin
        next_state = state;
        shifting   = 1'b0;
        last_bit   = 1'b0;
        cmd_ok     = 1'b1;
        accept     = 1'b0;
        word_next  = {din[ADDR_SIZE:0], MOSI};

        case (state)
            IDLE: begin
                if (!SS_n) begin
                    next_state = CHK_CMD;
                end
            end
            CHK_CMD: begin
                if (SS_n) begin
                    next_state = IDLE;
                end else if (!MOSI) begin
                    next_state = WRITE;
                end else if (rd_addr_pending) begin
                    next_state = READ_DATA;
                end else begin
                    next_state = READ_ADD;
                end
            end
            default: begin
                // Shifting states: an SS_n release always aborts, even on the 10th-bit edge.
                if (SS_n) begin
                    next_state = IDLE;
                end else if (bit_cnt != FULL_CNT) begin
                    shifting = 1'b1;
                end
            end
        endcase

        last_bit = shifting && (bit_cnt == LAST_BIT);
`ifdef SPI_CMD_CHECK_EN
        cmd_ok = cmd_matches(state, word_next[ADDR_SIZE+1:ADDR_SIZE]);
`endif
        accept = last_bit && cmd_ok;
    end

    // The RAM reply is taken only once per accepted read-data word, while the frame is still open.
    assign tx_load = rd_word_ok && !tx_busy && !tx_done && tx_valid && !SS_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            bit_cnt         <= '0;
            din             <= '0;
            rx_valid        <= 1'b0;
            rd_addr_pending <= 1'b0;
            rd_word_ok      <= 1'b0;
        end else begin
            state    <= next_state;
            rx_valid <= accept;

            if (shifting) begin
                din     <= word_next;
                bit_cnt <= bit_cnt + 4'd1;
            end else if (SS_n) begin
                bit_cnt <= '0;
            end

            if (accept && (state == READ_ADD)) begin
                rd_addr_pending <= 1'b1;
            end else if (accept && (state == READ_DATA)) begin
                rd_addr_pending <= 1'b0;
            end

            if (SS_n) begin
                rd_word_ok <= 1'b0;
            end else if (accept && (state == READ_DATA)) begin
                rd_word_ok <= 1'b1;
            end
        end
    end

`ifdef SPI_CMD_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_err <= 1'b0;
        end else if (last_bit && !cmd_ok) begin
            cmd_err <= 1'b1;
        end
    end
`else
    assign cmd_err = 1'b0;
`endif

    spi_tx_shifter #(
        .W(ADDR_SIZE)
    ) u_tx (
        .clk  (clk),
        .rst  (rst),
        .clear(SS_n),
        .load (tx_load),
        .data (dout),
        .miso (MISO),
        .busy (tx_busy),
        .done (tx_done)
    );

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Self-checking bench for spi_slave_ctrl: directed frame table, reset-mid-read sequence and random frames
// checked against a frame-level reference model. Honours SPI_CMD_CHECK_EN when defined.
module tb_spi_slave_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic [9:0] din;
    logic       rx_valid;
    logic [7:0] dout;
    logic       tx_valid;
    logic       cmd_err;

    spi_slave_ctrl #(.ADDR_SIZE(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .SS_n    (SS_n),
        .MOSI    (MOSI),
        .MISO    (MISO),
        .din     (din),
        .rx_valid(rx_valid),
        .dout    (dout),
        .tx_valid(tx_valid),
        .cmd_err (cmd_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       cmdBit;
        logic [9:0] word;
        int         nBits;
        int         txEdge;
        logic [7:0] ramByte;
        int         tail;
        bit         expRx;
        bit         expMiso;
        string      name;
    } vec_t;

    vec_t        vecs[14];
    int          checks = 0;
    int          errors = 0;
    int          edgeNo;
    int          rxCount;
    int          rxEdge;
    logic [9:0]  rxDin;
    logic [63:0] misoLog;
    bit          modelPending = 1'b0;
    bit          modelErr = 1'b0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // One clock: sample outputs 1 time unit after the rising edge and log the observations.
    task automatic tick();
        @(posedge clk);
        #1;
        edgeNo++;
        if (rx_valid) begin
            rxCount++;
            rxEdge = edgeNo;
            rxDin  = din;
        end
        if (edgeNo >= 1 && edgeNo <= 64) begin
            misoLog[edgeNo-1] = MISO;
        end
    endtask

    // Frame-level reference: what the slave should do with a frame given only the protocol rules.
    task automatic modelFrame(input logic cmdBit, input logic [9:0] word, input int nBits,
                              output bit accepted, output int kind);
        bit match;
        kind  = !cmdBit ? 0 : (modelPending ? 2 : 1);
        match = 1'b1;
`ifdef SPI_CMD_CHECK_EN
        case (kind)
            0:       match = (word[9] == 1'b0);
            1:       match = (word[9:8] == 2'b10);
            default: match = (word[9:8] == 2'b11);
        endcase
`endif
        accepted = (nBits == 10) && match;
        if (nBits == 10 && !match) modelErr = 1'b1;
        if (accepted && kind == 1) modelPending = 1'b1;
        else if (accepted && kind == 2) modelPending = 1'b0;
    endtask

    // Drive one frame: SS_n low for edges 1..lastLow, SS_n high at lastLow+1, then one idle gap edge.
    // nBits<10 aborts after that many word bits; nBits=-1 aborts while the command bit is sampled.
    task automatic applyStimulus(input logic cmdBit, input logic [9:0] word, input int nBits,
                                 input int txEdge, input logic [7:0] ramByte, input int tail,
                                 output int lastLow);
        lastLow = (nBits == 10) ? 12 + tail : 2 + nBits;
        edgeNo  = 0;
        rxCount = 0;
        rxEdge  = 0;
        rxDin   = '0;
        misoLog = '0;
        for (int e = 1; e <= lastLow + 2; e++) begin
            SS_n = (e > lastLow);
            if (e == 2) MOSI = cmdBit;
            else if (e >= 3 && (e - 3) < nBits && (e - 3) < 10) MOSI = word[9-(e-3)];
            else MOSI = 1'($urandom_range(0, 1));
            tx_valid = (e == txEdge);
            dout     = tx_valid ? ramByte : 8'($urandom);
            tick();
        end
        tx_valid = 1'b0;
    endtask

    task automatic checkFrame(input string name, input bit expRx, input bit expMiso, input logic [9:0] word,
                              input int txEdge, input logic [7:0] ramByte);
        logic [63:0] expVec;
        expVec = '0;
        if (expMiso) begin
            for (int k = 0; k < 8; k++) expVec[txEdge-1+k] = ramByte[7-k];
        end
        checkOutput({name, " rx_count"}, 64'(rxCount), 64'(expRx));
        if (expRx) begin
            checkOutput({name, " rx_edge"}, 64'(rxEdge), 64'd12);
            checkOutput({name, " rx_din"}, 64'(rxDin), 64'(word));
            checkOutput({name, " din_hold"}, 64'(din), 64'(word));
        end
        checkOutput({name, " miso_stream"}, misoLog, expVec);
        checkOutput({name, " cmd_err"}, 64'(cmd_err), 64'(modelErr));
    endtask

    initial begin
        bit         acc;
        int         kind;
        int         lastLow;
        logic       cmdBit;
        logic [9:0] word;
        logic [9:0] rdWord;
        int         nBits;
        int         txEdge;
        int         tail;
        logic [7:0] ramByte;

        vecs[0]  = '{1'b0, 10'h0A5, 10, 14, 8'h00, 2,  1'b1, 1'b0, "wr_addr"};
        vecs[1]  = '{1'b0, 10'h13C, 10, 15, 8'hAA, 10, 1'b1, 1'b0, "wr_data"};
        vecs[2]  = '{1'b1, 10'h2A5, 10, 14, 8'hFF, 12, 1'b1, 1'b0, "rd_addr"};
        vecs[3]  = '{1'b1, 10'h35A, 10, 14, 8'hC3, 12, 1'b1, 1'b1, "rd_data"};
        vecs[4]  = '{1'b0, 10'h1FF, 5,  0,  8'h00, 0,  1'b0, 1'b0, "abort_5bits"};
        vecs[5]  = '{1'b0, 10'h155, 10, 0,  8'h00, 1,  1'b1, 1'b0, "after_abort"};
        vecs[6]  = '{1'b0, 10'h0F0, 9,  0,  8'h00, 0,  1'b0, 1'b0, "abort_10th_edge"};
        vecs[7]  = '{1'b1, 10'h2C7, 10, 0,  8'h00, 1,  1'b1, 1'b0, "rd_addr2"};
        vecs[8]  = '{1'b1, 10'h3EE, 7,  0,  8'h00, 0,  1'b0, 1'b0, "rd_data_abort"};
        vecs[9]  = '{1'b1, 10'h2FF, -1, 0,  8'h00, 0,  1'b0, 1'b0, "abort_chk_cmd"};
        vecs[10] = '{1'b1, 10'h300, 10, 13, 8'h5A, 10, 1'b1, 1'b1, "rd_data2"};
        vecs[11] = '{1'b1, 10'h2AB, 10, 0,  8'h00, 1,  1'b1, 1'b0, "rd_addr3"};
        vecs[12] = '{1'b1, 10'h3CD, 10, 11, 8'h96, 4,  1'b1, 1'b0, "rd_data_early_tx"};
`ifdef SPI_CMD_CHECK_EN
        vecs[13] = '{1'b0, 10'h201, 10, 0,  8'h00, 1,  1'b0, 1'b0, "cmd_mismatch"};
`else
        vecs[13] = '{1'b0, 10'h201, 10, 0,  8'h00, 1,  1'b1, 1'b0, "cmd_mismatch"};
`endif

        rst      = 1'b1;
        SS_n     = 1'b1;
        MOSI     = 1'b0;
        tx_valid = 1'b0;
        dout     = '0;
        edgeNo   = 0;
        tick();
        tick();
        checkOutput("reset MISO", 64'(MISO), 64'd0);
        checkOutput("reset din", 64'(din), 64'd0);
        checkOutput("reset rx_valid", 64'(rx_valid), 64'd0);
        checkOutput("reset cmd_err", 64'(cmd_err), 64'd0);
        rst = 1'b0;
        tick();

        foreach (vecs[i]) begin
            modelFrame(vecs[i].cmdBit, vecs[i].word, vecs[i].nBits, acc, kind);
            applyStimulus(vecs[i].cmdBit, vecs[i].word, vecs[i].nBits, vecs[i].txEdge,
                          vecs[i].ramByte, vecs[i].tail, lastLow);
            checkFrame(vecs[i].name, vecs[i].expRx, vecs[i].expMiso, vecs[i].word,
                       vecs[i].txEdge, vecs[i].ramByte);
        end

        for (int n = 0; n < 60; n++) begin
            cmdBit  = 1'($urandom_range(0, 1));
            word    = 10'($urandom);
            nBits   = ($urandom_range(0, 3) != 0) ? 10 : int'($urandom_range(0, 10)) - 1;
            txEdge  = ($urandom_range(0, 1) != 0) ? int'($urandom_range(5, 20)) : 0;
            tail    = ((txEdge > 4) ? txEdge - 4 : 0) + int'($urandom_range(0, 2));
            ramByte = 8'($urandom);
            modelFrame(cmdBit, word, nBits, acc, kind);
            applyStimulus(cmdBit, word, nBits, txEdge, ramByte, tail, lastLow);
            checkFrame($sformatf("rand%0d", n), acc, acc && kind == 2 && txEdge >= 13 && txEdge <= lastLow,
                       word, txEdge, ramByte);
        end

        // Reset in the middle of MISO shifting: make sure a read address is pending first.
        if (!modelPending) begin
            modelFrame(1'b1, 10'h2A5, 10, acc, kind);
            applyStimulus(1'b1, 10'h2A5, 10, 0, 8'h00, 1, lastLow);
            checkFrame("pre_rst_rd_addr", acc, 1'b0, 10'h2A5, 0, 8'h00);
        end
        rdWord  = 10'h3C3;
        edgeNo  = 0;
        rxCount = 0;
        misoLog = '0;
        SS_n    = 1'b0;
        MOSI    = 1'b0;
        tick();
        MOSI = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            MOSI = rdWord[9-i];
            tick();
        end
        checkOutput("rst_seq rx_count", 64'(rxCount), 64'd1);
        tx_valid = 1'b1;
        dout     = 8'hC3;
        tick();
        tx_valid = 1'b0;
        checkOutput("rst_seq miso bit7", 64'(MISO), 64'd1);
        for (int i = 0; i < 6; i++) tick();
        checkOutput("rst_seq miso bit1", 64'(MISO), 64'd1);
        rst = 1'b1;
        tick();
        checkOutput("rst_seq miso after rst", 64'(MISO), 64'd0);
        checkOutput("rst_seq rx_valid after rst", 64'(rx_valid), 64'd0);
        checkOutput("rst_seq din after rst", 64'(din), 64'd0);
        checkOutput("rst_seq cmd_err after rst", 64'(cmd_err), 64'd0);
        rst  = 1'b0;
        SS_n = 1'b1;
        tick();
        modelPending = 1'b0;
        modelErr     = 1'b0;

        // With the pending flag cleared, a read frame must decode as a read address again.
        modelFrame(1'b1, 10'h2A5, 10, acc, kind);
        applyStimulus(1'b1, 10'h2A5, 10, 14, 8'hFF, 12, lastLow);
        checkFrame("post_rst_rd_addr", acc, acc && kind == 2, 10'h2A5, 14, 8'hFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
